rx_ring_writer: RTL and testbench
=================================

RX_RING_WRITER -- requirements
Module: rx_ring_writer

Interface
REQ-001 Parameter BUFFER_SIZE_RX_BITS, default 16, log2 of ring size in bytes; ring word is 128 bit (16 B).
REQ-002 s_ul_clk  in  1  sole clock.
REQ-003 s_ul_areset  in  1  reset, asynchronous, active-high.
REQ-004 fe_enable  in  1  frontend enabled; low clears all pointers.
REQ-005 fe_stall  in  1  ring stalled by DMA overflow handling; input dropped, pointers cleared.
REQ-006 fe_rst  in  1  frontend soft reset; same effect as fe_enable low.
REQ-007 fe_siso_mode  in  1  1 = beat carries 32 valid bits in [31:0]; 0 = 64 valid bits.
REQ-008 in_data  in  64  frontend sample beat.
REQ-009 in_valid  in  1  beat present; no ready, the frontend cannot be stalled.
REQ-010 ram_wr_en  out  1  ring RAM write strobe.
REQ-011 ram_waddr  out  BUFFER_SIZE_RX_BITS-4  ring word address.
REQ-012 ram_wdata  out  128  packed ring word.
REQ-013 writer_pos  out  3  completed ring words mod 8, consumed by the RX DMA state machine.
REQ-014 drop_cnt  out  16  beats dropped while stalled, saturating.

Function
REQ-015 Block SHALL be active when fe_enable=1, fe_rst=0 and fe_stall=0; otherwise "cleared".
REQ-016 While cleared, pack lane index, partial word, ram_waddr and writer_pos SHALL be held at 0, and ram_wr_en SHALL be 0.
REQ-017 MIMO packing: the first valid beat fills ram_wdata[63:0] and the second fills [127:64].
REQ-018 SISO packing: four valid beats fill [31:0], [63:32], [95:64] and [127:96] in order; in_data[63:32] is ignored.
REQ-019 fe_siso_mode SHALL be sampled only while cleared; changes while active are ignored.
REQ-020 On the beat completing a word, ram_wr_en SHALL assert on the next cycle, for exactly 1 cycle, with the word and its ram_waddr.
REQ-021 ram_waddr SHALL increment by 1 the cycle after each write and wrap from all-ones to 0.
REQ-022 writer_pos SHALL equal (words written) mod 8, updated one cycle after ram_wr_en, so RAM data precedes visibility.
REQ-023 Beats are accepted every cycle; back-to-back in_valid SHALL sustain 1 word per 2 cycles (MIMO) or per 4 cycles (SISO) with no loss.
REQ-024 A beat with in_valid=1 while fe_stall=1 and fe_enable=1 SHALL increment drop_cnt, which saturates at 0xFFFF.
REQ-025 drop_cnt SHALL clear when fe_enable is 0 or fe_rst is 1, and SHALL NOT clear on fe_stall.
REQ-026 Entering the cleared state mid-word SHALL discard the partial word with no write; a write already registered SHALL complete, but writer_pos SHALL still read 0 after clearing.
REQ-027 Leaving the cleared state SHALL resume packing at lane 0 and address 0 on the next valid beat.
REQ-028 The block SHALL NOT check for overrun; ring overflow detection belongs to the DMA state machine.

Reset
REQ-029 Asserting s_ul_areset SHALL immediately drive all outputs and internal state to 0, regardless of clock.
REQ-030 Reset release SHALL be synchronised to s_ul_clk with a 2-flop release; the first beat is accepted no earlier than 2 cycles after deassertion.

Structure
REQ-031 Ring word width (128), POS_BITS (3) and the SISO/MIMO lane counts SHALL be constants in the shared RX DMA package, common with the DMA state machine.
REQ-032 Implementation SHALL be a single module with no sub-module; the RAM is external.

Verification
REQ-033 MIMO, beats 0x1..0x10 back-to-back -> 8 writes, addr 0..7, word0 = {0x2,0x1}, writer_pos sequence 1..7,0.
REQ-034 SISO, 8 beats 0xA0..0xA7 -> 2 writes; word0 [31:0]=0xA0 and [127:96]=0xA3.
REQ-035 fe_stall pulse after 3 MIMO beats, 5 beats during stall -> word0 written, partial discarded, drop_cnt=5, next write at addr 0.
REQ-036 Run 2^(BUFFER_SIZE_RX_BITS-4)+1 words -> ram_waddr wraps to 0 and the last write is at addr 0.
REQ-037 70000 beats during stall -> drop_cnt=0xFFFF; fe_enable low -> 0.
REQ-038 s_ul_areset asserted mid-word, between clock edges -> outputs 0 before the next edge.

Source files
------------

// File: rtl/rx_ring_writer_pkg.sv
// Shared RX DMA constants and packing helpers used by the ring writer and the DMA state machine.
package rx_ring_writer_pkg;

  localparam int unsigned RING_WORD_BITS = 128;
  localparam int unsigned BEAT_BITS      = 64;
  localparam int unsigned POS_BITS       = 3;
  localparam int unsigned SISO_LANES     = 4;
  localparam int unsigned MIMO_LANES     = 2;
  localparam int unsigned LANE_BITS      = 2;
  localparam int unsigned DROP_BITS      = 16;

  typedef enum logic {
    PACK_MIMO = 1'b0,
    PACK_SISO = 1'b1
  } pack_mode_e;

  // Lane index of the beat that completes a ring word.
  function automatic logic [LANE_BITS-1:0] last_lane(input pack_mode_e mode);
    return (mode == PACK_SISO) ? LANE_BITS'(SISO_LANES - 1) : LANE_BITS'(MIMO_LANES - 1);
  endfunction

  // Merge one beat into the partial ring word at the given lane.
  function automatic logic [RING_WORD_BITS-1:0] place_beat(
    input logic [RING_WORD_BITS-1:0] word,
    input logic [BEAT_BITS-1:0]      beat,
    input logic [LANE_BITS-1:0]      lane,
    input pack_mode_e                mode
  );
    logic [RING_WORD_BITS-1:0] w;
    w = word;
    if (mode == PACK_SISO) begin
      case (lane)
        2'd0: w[31:0]   = beat[31:0];
        2'd1: w[63:32]  = beat[31:0];
        2'd2: w[95:64]  = beat[31:0];
        2'd3: w[127:96] = beat[31:0];
      endcase
    end else if (lane[0]) begin
      w[127:64] = beat;
    end else begin
      w[63:0] = beat;
    end
    return w;
  endfunction

endpackage

// File: rtl/rx_ring_writer.sv
// Packs frontend sample beats into 128-bit ring words and writes them to the external RX ring RAM.
module rx_ring_writer
  import rx_ring_writer_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE_RX_BITS = 16
) (
  input  logic                           s_ul_clk,
  input  logic                           s_ul_areset,
  input  logic                           fe_enable,
  input  logic                           fe_stall,
  input  logic                           fe_rst,
  input  logic                           fe_siso_mode,
  input  logic [BEAT_BITS-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           ram_wr_en,
  output logic [BUFFER_SIZE_RX_BITS-5:0] ram_waddr,
  output logic [RING_WORD_BITS-1:0]      ram_wdata,
  output logic [POS_BITS-1:0]            writer_pos,
  output logic [DROP_BITS-1:0]           drop_cnt
);

  localparam int unsigned ADDR_BITS = BUFFER_SIZE_RX_BITS - 4;

  logic rst_meta;
  logic rst_sync;

  // Assert immediately, release two clocks later.
  always_ff @(posedge s_ul_clk or posedge s_ul_areset) begin
    if (s_ul_areset) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  logic active_c;
  logic drop_clear_c;

  assign active_c     = fe_enable & ~fe_rst & ~fe_stall & ~rst_sync;
  assign drop_clear_c = ~fe_enable | fe_rst | rst_sync;

  pack_mode_e                mode, mode_nxt;
  logic [LANE_BITS-1:0]      lane, lane_nxt;
  logic [RING_WORD_BITS-1:0] word, word_nxt;
  logic                      wr_en_nxt;
  logic [ADDR_BITS-1:0]      waddr_nxt;
  logic [RING_WORD_BITS-1:0] wdata_nxt;
  logic [POS_BITS-1:0]       pos_nxt;
  logic [DROP_BITS-1:0]      drop_nxt;

  // Pointer and packing next-state; pointers only advance after a write has been presented.
  always_comb begin
    mode_nxt  = mode;
    lane_nxt  = lane;
    word_nxt  = word;
    wr_en_nxt = 1'b0;
    waddr_nxt = ram_waddr;
    wdata_nxt = ram_wdata;
    pos_nxt   = writer_pos;
    drop_nxt  = drop_cnt;

    if (!active_c) begin
      mode_nxt  = pack_mode_e'(fe_siso_mode);
      lane_nxt  = '0;
      word_nxt  = '0;
      waddr_nxt = '0;
      pos_nxt   = '0;
    end else begin
      if (ram_wr_en) begin
        waddr_nxt = ram_waddr + ADDR_BITS'(1);
        pos_nxt   = writer_pos + POS_BITS'(1);
      end
      if (in_valid) begin
        word_nxt = place_beat(word, in_data, lane, mode);
        if (lane == last_lane(mode)) begin
          wr_en_nxt = 1'b1;
          wdata_nxt = word_nxt;
          word_nxt  = '0;
          lane_nxt  = '0;
        end else begin
          lane_nxt = lane + LANE_BITS'(1);
        end
      end
    end

    // Stall keeps the drop history so software can read it after recovery.
    if (drop_clear_c) begin
      drop_nxt = '0;
    end else if (fe_stall && in_valid && (drop_cnt != '1)) begin
      drop_nxt = drop_cnt + DROP_BITS'(1);
    end
  end

  always_ff @(posedge s_ul_clk or posedge s_ul_areset) begin
    if (s_ul_areset) begin
      mode       <= PACK_MIMO;
      lane       <= '0;
      word       <= '0;
      ram_wr_en  <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      writer_pos <= '0;
      drop_cnt   <= '0;
    end else begin
      mode       <= mode_nxt;
      lane       <= lane_nxt;
      word       <= word_nxt;
      ram_wr_en  <= wr_en_nxt;
      ram_waddr  <= waddr_nxt;
      ram_wdata  <= wdata_nxt;
      writer_pos <= pos_nxt;
      drop_cnt   <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_rx_ring_writer.sv
// Scoreboard bench for rx_ring_writer: a beat-level packing model predicts every ring write.
module tb_rx_ring_writer;

  localparam int unsigned ADDR_BITS = 12;
  localparam int unsigned WRAP_WORDS = (1 << ADDR_BITS) + 1;

  logic                 clk;
  logic                 areset;
  logic                 fe_enable;
  logic                 fe_stall;
  logic                 fe_rst;
  logic                 fe_siso_mode;
  logic [63:0]          in_data;
  logic                 in_valid;
  logic                 ram_wr_en;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [127:0]         ram_wdata;
  logic [2:0]           writer_pos;
  logic [15:0]          drop_cnt;

  rx_ring_writer #(.BUFFER_SIZE_RX_BITS(16)) dut (
    .s_ul_clk     (clk),
    .s_ul_areset  (areset),
    .fe_enable    (fe_enable),
    .fe_stall     (fe_stall),
    .fe_rst       (fe_rst),
    .fe_siso_mode (fe_siso_mode),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .ram_wr_en    (ram_wr_en),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .writer_pos   (writer_pos),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [127:0]         data;
  } exp_t;

  exp_t                 sb[$];
  logic [127:0]         log_data[$];
  logic [ADDR_BITS-1:0] log_addr[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic                 model_on;
  logic                 m_siso;
  int unsigned          m_lane;
  logic [127:0]         m_word;
  logic [ADDR_BITS-1:0] m_addr;
  logic [2:0]           m_pos;
  logic                 track_pos;
  logic                 pos_pending;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input logic siso);
    m_siso      = siso;
    m_lane      = 0;
    m_word      = '0;
    m_addr      = '0;
    m_pos       = '0;
    pos_pending = 1'b0;
  endtask

  // Reference packing: lanes are 64 bits wide in MIMO, 32 bits in SISO.
  task automatic model_beat(input logic [63:0] d);
    exp_t        e;
    int unsigned last;
    if (m_siso) m_word = m_word | ({96'b0, d[31:0]} << (32 * m_lane));
    else        m_word = m_word | ({64'b0, d} << (64 * m_lane));
    last = m_siso ? 3 : 1;
    if (m_lane == last) begin
      e.addr = m_addr;
      e.data = m_word;
      sb.push_back(e);
      m_addr = m_addr + 1'b1;
      m_word = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d);
    tick();
    in_valid = 1'b1;
    in_data  = d;
    if (model_on) model_beat(d);
  endtask

  // Pass through the cleared state so the packing mode is sampled.
  task automatic restart(input logic siso);
    tick();
    fe_enable    = 1'b0;
    fe_siso_mode = siso;
    tick();
    fe_enable = 1'b1;
    model_clear(siso);
    model_on = 1'b1;
    log_data.delete();
    log_addr.delete();
  endtask

  task automatic drain(input string tag);
    repeat (6) tick();
    chk(tag, 128'(sb.size()), 128'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pos_pending) begin
      chk("writer_pos", 128'(writer_pos), 128'(m_pos));
      pos_pending = 1'b0;
    end
    if (ram_wr_en) begin
      log_data.push_back(ram_wdata);
      log_addr.push_back(ram_waddr);
      if (sb.size() == 0) begin
        chk("unexpected_wr", 128'(1), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 128'(ram_waddr), 128'(e.addr));
        chk("wr_data", ram_wdata, e.data);
      end
      if (track_pos) begin
        m_pos       = m_pos + 1'b1;
        pos_pending = 1'b1;
      end
    end
  end

  initial begin
    areset       = 1'b1;
    fe_enable    = 1'b0;
    fe_stall     = 1'b0;
    fe_rst       = 1'b0;
    fe_siso_mode = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    model_on     = 1'b0;
    track_pos    = 1'b0;
    model_clear(1'b0);

    #12;
    chk("rst_wr_en", 128'(ram_wr_en), 128'(0));
    chk("rst_waddr", 128'(ram_waddr), 128'(0));
    chk("rst_wdata", ram_wdata, 128'(0));
    chk("rst_pos", 128'(writer_pos), 128'(0));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    areset = 1'b0;
    repeat (3) tick();

    // MIMO back-to-back, 16 beats -> 8 words
    track_pos = 1'b1;
    restart(1'b0);
    for (int i = 1; i <= 16; i++) beat(64'(i));
    drain("t1_sb_empty");
    chk("t1_n_wr", 128'(log_data.size()), 128'(8));
    if (log_data.size() > 0) chk("t1_word0", log_data[0], {64'h2, 64'h1});
    if (log_addr.size() == 8) chk("t1_last_addr", 128'(log_addr[7]), 128'(7));
    chk("t1_pos_end", 128'(writer_pos), 128'(0));

    // SISO, mode flipped mid-run must be ignored
    restart(1'b1);
    for (int i = 0; i < 8; i++) begin
      beat(64'hDEAD_BEEF_0000_00A0 + 64'(i));
      if (i == 2) fe_siso_mode = 1'b0;
    end
    drain("t2_sb_empty");
    chk("t2_n_wr", 128'(log_data.size()), 128'(2));
    if (log_data.size() > 0) begin
      chk("t2_w0_lo", 128'(log_data[0][31:0]), 128'(32'hA0));
      chk("t2_w0_hi", 128'(log_data[0][127:96]), 128'(32'hA3));
    end

    // Stall pulse after 3 MIMO beats
    track_pos = 1'b0;
    restart(1'b0);
    beat(64'h31);
    beat(64'h32);
    beat(64'h33);
    model_on = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      fe_stall = 1'b1;
      in_valid = 1'b1;
      in_data  = 64'($urandom);
    end
    tick();
    fe_stall = 1'b0;
    chk("t3_drop", 128'(drop_cnt), 128'(5));
    chk("t3_pos_clr", 128'(writer_pos), 128'(0));
    chk("t3_addr_clr", 128'(ram_waddr), 128'(0));
    model_clear(1'b0);
    model_on = 1'b1;
    beat(64'h34);
    beat(64'h35);
    drain("t3_sb_empty");
    chk("t3_drop_kept", 128'(drop_cnt), 128'(5));
    if (log_addr.size() == 2) chk("t3_resume_addr", 128'(log_addr[1]), 128'(0));
    else chk("t3_n_wr", 128'(log_addr.size()), 128'(2));
    fe_enable = 1'b0;
    tick();
    tick();
    chk("t3_drop_en_clr", 128'(drop_cnt), 128'(0));

    // Address wrap over the whole ring plus one word
    track_pos = 1'b1;
    restart(1'b0);
    for (int i = 0; i < 2 * WRAP_WORDS; i++) beat({32'hC0DE_0000, 32'(i)});
    drain("t4_sb_empty");
    chk("t4_n_wr", 128'(log_addr.size()), 128'(WRAP_WORDS));
    if (log_addr.size() > 0) chk("t4_last_addr", 128'(log_addr[log_addr.size() - 1]), 128'(0));

    // Drop counter saturation
    track_pos = 1'b0;
    restart(1'b0);
    model_on = 1'b0;
    fe_stall = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      tick();
      in_valid = 1'b1;
      in_data  = 64'(i);
    end
    tick();
    chk("t5_drop_sat", 128'(drop_cnt), 128'(16'hFFFF));
    fe_stall = 1'b0;
    tick();
    chk("t5_drop_hold", 128'(drop_cnt), 128'(16'hFFFF));
    fe_rst = 1'b1;
    tick();
    tick();
    chk("t5_drop_rst_clr", 128'(drop_cnt), 128'(0));
    fe_rst    = 1'b0;
    fe_enable = 1'b0;
    tick();
    chk("t5_drop_en_low", 128'(drop_cnt), 128'(0));
    chk("t4_unexp_empty", 128'(sb.size()), 128'(0));

    // Async reset between clock edges, mid-word
    restart(1'b0);
    tick();
    fe_stall = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    fe_stall = 1'b0;
    model_clear(1'b0);
    beat(64'h51);
    beat(64'h52);
    beat(64'h53);
    @(posedge clk);
    #3;
    chk("t6_pre_addr", 128'(ram_waddr), 128'(1));
    chk("t6_pre_drop", 128'(drop_cnt), 128'(2));
    areset = 1'b1;
    #1;
    chk("t6_wr_en", 128'(ram_wr_en), 128'(0));
    chk("t6_waddr", 128'(ram_waddr), 128'(0));
    chk("t6_wdata", ram_wdata, 128'(0));
    chk("t6_pos", 128'(writer_pos), 128'(0));
    chk("t6_drop", 128'(drop_cnt), 128'(0));
    in_valid = 1'b0;
    repeat (2) tick();
    areset = 1'b0;
    repeat (3) tick();
    chk("t6_sb_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
